// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side requests in, stall/flush/MDU status out.
// Latency: pure wiring, no storage.
// Backpressure: none here; the stall vector carried back is the pipeline's backpressure.
interface pipeline_hazard_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  load_related_1;
  logic                  load_related_2;
  logic                  mdu_start;
  logic                  stall_req_mem;
  logic                  exc_valid;
  logic [ADDR_WIDTH-1:0] exc_handler_pc;
  logic [5:0]            stall;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flush_pc;
  logic                  mdu_busy;
  logic                  mdu_done;

  // Pipeline side: raises hazard requests, obeys stall/flush.
  modport master (
    output load_related_1, load_related_2, mdu_start, stall_req_mem,
           exc_valid, exc_handler_pc,
    input  stall, flush, flush_pc, mdu_busy, mdu_done
  );

  // Controller side.
  modport slave (
    input  load_related_1, load_related_2, mdu_start, stall_req_mem,
           exc_valid, exc_handler_pc,
    output stall, flush, flush_pc, mdu_busy, mdu_done
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: folds load-use, MDU, memory-stall and exception requests into per-stage stalls.
// Latency: stall/mdu_done are combinational in the request cycle; flush/flush_pc appear the cycle after an exception.
// Backpressure: the stall vector freezes upstream stages; an exception overrides every stall and is never held off.
module pipeline_hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_WIDTH   = 6,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  // Stall encodings, bit order {wb,mem,ex,id,if,pc}.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LOAD = 6'b000111;  // hold PC/IF/ID, bubble into EX
  localparam logic [5:0] STALL_MDU  = 6'b001111;  // additionally freeze EX
  localparam logic [5:0] STALL_MEM  = 6'b011111;  // additionally freeze MEM

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MDU_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] flush_pc_q;
  logic [5:0]            stall_c;
  logic                  done_c;
  logic                  capture_pc;
  logic                  load_hz;

  assign load_hz = hz.load_related_1 | hz.load_related_2;

  // State and MDU down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect target is latched only when an exception is accepted and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pc_q <= '0;
    end else if (capture_pc) begin
      flush_pc_q <= hz.exc_handler_pc;
    end
  end

  // Priority resolution: exception > memory stall > MDU > load-use.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = STALL_NONE;
    done_c     = 1'b0;
    capture_pc = 1'b0;

    unique case (state_q)
      RUN: begin
        if (hz.exc_valid) begin
          capture_pc = 1'b1;
          state_d    = FLUSH;
        end else if (hz.stall_req_mem) begin
          // MDU issue is refused this cycle; EX will re-present it.
          stall_c = STALL_MEM;
        end else if (hz.mdu_start) begin
          // Issue cycle already counts as one of the MDU_LATENCY stall cycles.
          stall_c = STALL_MDU;
          cnt_d   = CNT_LOAD;
          state_d = MDU_WAIT;
        end else if (load_hz) begin
          stall_c = STALL_LOAD;
        end
      end

      MDU_WAIT: begin
        if (hz.exc_valid) begin
          // Abort the in-flight operation; no done pulse will follow.
          cnt_d      = '0;
          capture_pc = 1'b1;
          state_d    = FLUSH;
        end else if (hz.stall_req_mem) begin
          // Whole pipe frozen, so the MDU countdown pauses too.
          stall_c = STALL_MEM;
        end else if (cnt_q != '0) begin
          stall_c = STALL_MDU;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          done_c  = 1'b1;
          stall_c = load_hz ? STALL_LOAD : STALL_NONE;
          state_d = RUN;
        end
      end

      FLUSH: begin
        // Everything in MEM and upstream is being discarded, including any new exception.
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Combinational outputs read as idle for as long as reset is held.
    if (rst) begin
      stall_c = STALL_NONE;
      done_c  = 1'b0;
    end
  end

  assign hz.stall    = stall_c;
  assign hz.mdu_done = done_c;
  assign hz.mdu_busy = (state_q == MDU_WAIT);
  assign hz.flush    = (state_q == FLUSH);
  assign hz.flush_pc = flush_pc_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for the hazard sequencer: directed scenarios plus randomized traffic against a cycle model.
// Latency: outputs sampled at the falling edge, model stepped at the rising edge.
// Backpressure: not applicable; inputs are free-running requests.
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 12;

  typedef struct packed {
    logic        l1;
    logic        l2;
    logic        ms;
    logic        mem;
    logic        exc;
    logic [31:0] pc;
  } stim_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] fpc;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.ADDR_WIDTH(32)) hz();

  pipeline_hazard_ctrl #(
    .MDU_LATENCY(LAT),
    .CNT_WIDTH  (4),
    .ADDR_WIDTH (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a pending flush, whether an MDU op owns EX, how many
  // more stall cycles it is owed before its result appears, and the last redirect.
  bit          m_flush;
  bit          m_in_mdu;
  int          m_left;
  logic [31:0] m_fpc;

  function automatic stim_t mk(input int l1, input int l2, input int ms,
                               input int mem, input int exc, input logic [31:0] pc);
    stim_t s;
    s.l1 = (l1 != 0); s.l2 = (l2 != 0); s.ms = (ms != 0);
    s.mem = (mem != 0); s.exc = (exc != 0); s.pc = pc;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hz.load_related_1 = s.l1;
    hz.load_related_2 = s.l2;
    hz.mdu_start      = s.ms;
    hz.stall_req_mem  = s.mem;
    hz.exc_valid      = s.exc;
    hz.exc_handler_pc = s.pc;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.stall = hz.stall; o.flush = hz.flush; o.fpc = hz.flush_pc;
    o.busy = hz.mdu_busy; o.done = hz.mdu_done;
    return o;
  endfunction

  task automatic model_reset();
    m_flush = 0; m_in_mdu = 0; m_left = 0; m_fpc = '0;
  endtask

  function automatic obs_t model_exp();
    obs_t e;
    logic ld;
    ld = hz.load_related_1 | hz.load_related_2;
    e = '0;
    e.flush = m_flush; e.fpc = m_fpc; e.busy = m_in_mdu;
    if (m_flush || hz.exc_valid) e.stall = 6'h00;
    else if (hz.stall_req_mem) e.stall = 6'h1F;
    else if (m_in_mdu) begin
      if (m_left > 0) e.stall = 6'h0F;
      else begin e.done = 1'b1; e.stall = ld ? 6'h07 : 6'h00; end
    end
    else if (hz.mdu_start) e.stall = 6'h0F;
    else if (ld) e.stall = 6'h07;
    return e;
  endfunction

  task automatic model_advance();
    if (m_flush) m_flush = 0;
    else if (hz.exc_valid) begin
      m_flush = 1; m_fpc = hz.exc_handler_pc; m_in_mdu = 0; m_left = 0;
    end
    else if (hz.stall_req_mem) begin end
    else if (m_in_mdu) begin
      if (m_left > 0) m_left = m_left - 1;
      else m_in_mdu = 0;
    end
    else if (hz.mdu_start) begin m_in_mdu = 1; m_left = LAT - 1; end
  endtask

  task automatic test_reset();
    obs_t got;
    apply(mk(0, 0, 0, 0, 0, 0));
    hz.load_related_1 = 1'b1;
    #2;
    got = observe();
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL reset_held got %h want 0", got); end
    hz.load_related_1 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    model_reset();
    #1;
    got = observe();
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL reset_release got %h want 0", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    stim_t q[$];
    obs_t got, exp;
    q.push_back(mk(1, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 1, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL load cyc %0d got %h want %h", i, got, exp); end
      if (i == 0 || i == 2) begin
        vectors++;
        if (got.stall !== 6'b000111 || got.flush !== 1'b0) begin
          miscompares++; $display("FAIL load_stall cyc %0d got %b/%b want 000111/0", i, got.stall, got.flush);
        end
      end
      if (i == 1) begin
        vectors++;
        if (got.stall !== 6'b000000) begin miscompares++; $display("FAIL load_release got %b want 000000", got.stall); end
      end
      @(posedge clk); model_advance(); #1;
    end
  endtask

  task automatic test_mdu();
    stim_t q[$];
    obs_t got, exp;
    int n_stall = 0;
    int done_at = -1;
    q.push_back(mk(0, 0, 1, 0, 0, 0));
    for (int k = 0; k < LAT + 3; k++) q.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL mdu cyc %0d got %h want %h", i, got, exp); end
      if (got.stall === 6'b001111) n_stall++;
      if (got.done === 1'b1) done_at = i;
      @(posedge clk); model_advance(); #1;
    end
    vectors++;
    if (n_stall !== LAT) begin miscompares++; $display("FAIL mdu_stall_count got %0d want %0d", n_stall, LAT); end
    vectors++;
    if (done_at !== LAT) begin miscompares++; $display("FAIL mdu_done_cycle got %0d want %0d", done_at, LAT); end
  endtask

  task automatic test_mem_during_mdu();
    stim_t q[$];
    obs_t got, exp;
    int done_at = -1;
    q.push_back(mk(0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= LAT - 3; k++) q.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, 1, 1, 0, 0));
    for (int k = 0; k < 7; k++) q.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL mem_mdu cyc %0d got %h want %h", i, got, exp); end
      if (i >= LAT - 2 && i <= LAT) begin
        vectors++;
        if (got.stall !== 6'b011111 || got.done !== 1'b0) begin
          miscompares++; $display("FAIL mem_mdu_hold cyc %0d got %b/%b want 011111/0", i, got.stall, got.done);
        end
      end
      if (got.done === 1'b1) done_at = i;
      @(posedge clk); model_advance(); #1;
    end
    vectors++;
    if (done_at !== LAT + 3) begin miscompares++; $display("FAIL mem_mdu_done got %0d want %0d", done_at, LAT + 3); end
  endtask

  task automatic test_exc_priority();
    stim_t q[$];
    obs_t got, exp;
    q.push_back(mk(1, 1, 1, 0, 1, 32'hBFC0_0380));
    for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, 0, 0, 0, 32'h1234_5678));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL exc_prio cyc %0d got %h want %h", i, got, exp); end
      if (i == 0) begin
        vectors++;
        if (got.stall !== 6'b0 || got.flush !== 1'b0) begin miscompares++; $display("FAIL exc_prio_stall got %b want 000000", got.stall); end
      end
      if (i == 1) begin
        vectors++;
        if (got.flush !== 1'b1 || got.fpc !== 32'hBFC0_0380 || got.busy !== 1'b0 || got.done !== 1'b0) begin
          miscompares++; $display("FAIL exc_prio_flush got f=%b pc=%h b=%b d=%b want 1/bfc00380/0/0", got.flush, got.fpc, got.busy, got.done);
        end
      end
      if (i == 2) begin
        vectors++;
        if (got.flush !== 1'b0 || got.fpc !== 32'hBFC0_0380) begin
          miscompares++; $display("FAIL exc_prio_after got f=%b pc=%h want 0/bfc00380", got.flush, got.fpc);
        end
      end
      @(posedge clk); model_advance(); #1;
    end
  endtask

  task automatic test_exc_abort();
    stim_t q[$];
    obs_t got, exp;
    logic [31:0] hpc;
    hpc = $urandom;
    q.push_back(mk(0, 0, 1, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 1, 0, 1, hpc));     // counter is at LAT-2 = 10 here
    q.push_back(mk(0, 0, 1, 1, 1, ~hpc));    // ignored while flushing
    q.push_back(mk(0, 0, 1, 0, 0, 0));
    for (int k = 0; k < LAT + 1; k++) q.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL exc_abort cyc %0d got %h want %h", i, got, exp); end
      if (i == 3) begin
        vectors++;
        if (got.flush !== 1'b1 || got.stall !== 6'b0 || got.fpc !== hpc || got.done !== 1'b0) begin
          miscompares++; $display("FAIL exc_abort_flush got f=%b s=%b pc=%h d=%b want 1/000000/%h/0", got.flush, got.stall, got.fpc, got.done, hpc);
        end
      end
      if (i == 4) begin
        vectors++;
        if (got.stall !== 6'b001111 || got.busy !== 1'b0) begin
          miscompares++; $display("FAIL exc_abort_reissue got s=%b b=%b want 001111/0", got.stall, got.busy);
        end
      end
      if (i == 5) begin
        vectors++;
        if (got.busy !== 1'b1) begin miscompares++; $display("FAIL exc_abort_busy got %b want 1", got.busy); end
      end
      @(posedge clk); model_advance(); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    obs_t got, exp;
    q.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0180));
    q.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0200));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL b2b cyc %0d got %h want %h", i, got, exp); end
      if (i == 2) begin
        vectors++;
        if (got.flush !== 1'b0 || got.fpc !== 32'h8000_0180) begin
          miscompares++; $display("FAIL b2b_dropped got f=%b pc=%h want 0/80000180", got.flush, got.fpc);
        end
      end
      @(posedge clk); model_advance(); #1;
    end
  endtask

  task automatic test_async_reset();
    stim_t q[$];
    obs_t got, exp;
    q.push_back(mk(0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL arst_pre cyc %0d got %h want %h", i, got, exp); end
      @(posedge clk); model_advance(); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    got = observe();
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL arst_immediate got %h want 0", got); end
    @(posedge clk); #3;
    rst = 1'b0;
    model_reset();
    #1;
    got = observe();
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL arst_release got %h want 0", got); end
    @(posedge clk); #1;
    q.delete();
    q.push_back(mk(0, 0, 1, 0, 0, 0));
    for (int k = 0; k < LAT + 1; k++) q.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL arst_post cyc %0d got %h want %h", i, got, exp); end
      @(posedge clk); model_advance(); #1;
    end
  endtask

  task automatic test_random();
    stim_t s;
    obs_t got, exp;
    for (int i = 0; i < 3000; i++) begin
      s.l1  = ($urandom_range(0, 3) == 0);
      s.l2  = ($urandom_range(0, 3) == 0);
      s.ms  = ($urandom_range(0, 3) == 0);
      s.mem = ($urandom_range(0, 5) == 0);
      s.exc = ($urandom_range(0, 15) == 0);
      s.pc  = $urandom;
      apply(s); @(negedge clk);
      exp = model_exp(); got = observe();
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL random cyc %0d got %h want %h", i, got, exp); end
      @(posedge clk); model_advance(); #1;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_mdu();
    test_mem_during_mdu();
    test_exc_priority();
    test_exc_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
